// File: rtl/dispatch_pkg.sv
// Shared opcode ranges and classification helpers for the dispatch queue.
package dispatch_pkg;

   localparam int unsigned OPC_W = 6;

   localparam logic [OPC_W-1:0] OP_ADDI = 6'h01;
   localparam logic [OPC_W-1:0] OP_BEQ  = 6'h10;
   localparam logic [OPC_W-1:0] OP_BGEU = 6'h15;
   localparam logic [OPC_W-1:0] OP_SB   = 6'h18;
   localparam logic [OPC_W-1:0] OP_SW   = 6'h1A;

   localparam int unsigned TAG_NONE = 0;

   function automatic logic is_branch(input logic [OPC_W-1:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

   function automatic logic is_store(input logic [OPC_W-1:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

endpackage

// File: rtl/operand_resolver.sv
// Picks one source operand from regfile, ROB or CDB, else returns the producer tag.
module operand_resolver
   import dispatch_pkg::*;
#(
   parameter int unsigned CDB_PORTS = 2,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned TAG_W     = 4
) (
   input  logic                          reg_zero_in,
   input  logic                          rf_busy_in,
   input  logic [DATA_W-1:0]             rf_val_in,
   input  logic [TAG_W-1:0]              rf_tag_in,
   input  logic                          rob_ready_in,
   input  logic [DATA_W-1:0]             rob_val_in,
   input  logic [CDB_PORTS-1:0]          cdb_valid_in,
   input  logic [CDB_PORTS*TAG_W-1:0]    cdb_tag_in,
   input  logic [CDB_PORTS*DATA_W-1:0]   cdb_val_in,
   output logic [DATA_W-1:0]             val_out,
   output logic [TAG_W-1:0]              tag_out
);

   logic              cdb_hit;
   logic [DATA_W-1:0] cdb_val;

   // Scan from the top so the lowest matching port is the one left standing.
   always_comb begin
      cdb_hit = 1'b0;
      cdb_val = '0;
      for (int i = CDB_PORTS - 1; i >= 0; i--) begin
         if (cdb_valid_in[i] && (cdb_tag_in[i*TAG_W +: TAG_W] == rf_tag_in)) begin
            cdb_hit = 1'b1;
            cdb_val = cdb_val_in[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      val_out = '0;
      tag_out = TAG_W'(TAG_NONE);
      if (reg_zero_in) begin
         val_out = '0;
      end else if (!rf_busy_in) begin
         val_out = rf_val_in;
      end else if (rob_ready_in) begin
         val_out = rob_val_in;
      end else if (cdb_hit) begin
         val_out = cdb_val;
      end else begin
         tag_out = rf_tag_in;
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction queue that resolves head operands and dispatches to RS/ROB.
module dispatch_queue
   import dispatch_pkg::*;
#(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned CDB_PORTS = 2,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned REG_W     = 5,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned OP_W      = 6
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        flush_in,
   input  logic                        dec_valid_in,
   output logic                        dec_ready_out,
   input  logic [REG_W-1:0]            dec_rs_in,
   input  logic [REG_W-1:0]            dec_rt_in,
   input  logic [REG_W-1:0]            dec_rd_in,
   input  logic [DATA_W-1:0]           dec_imm_in,
   input  logic [OP_W-1:0]             dec_op_in,
   input  logic [ADDR_W-1:0]           dec_pc_in,
   input  logic [ADDR_W-1:0]           dec_target_in,
   input  logic                        dec_taken_in,
   output logic [REG_W-1:0]            rf_rs_out,
   output logic [REG_W-1:0]            rf_rt_out,
   input  logic                        rf_rs_busy_in,
   input  logic                        rf_rt_busy_in,
   input  logic [DATA_W-1:0]           rf_rs_val_in,
   input  logic [DATA_W-1:0]           rf_rt_val_in,
   input  logic [TAG_W-1:0]            rf_rs_tag_in,
   input  logic [TAG_W-1:0]            rf_rt_tag_in,
   output logic [TAG_W-1:0]            rob_rs_h_out,
   output logic [TAG_W-1:0]            rob_rt_h_out,
   input  logic                        rob_rs_ready_in,
   input  logic                        rob_rt_ready_in,
   input  logic [DATA_W-1:0]           rob_rs_val_in,
   input  logic [DATA_W-1:0]           rob_rt_val_in,
   input  logic [TAG_W-1:0]            rob_free_tag_in,
   input  logic                        rob_ready_in,
   input  logic                        rs_ready_in,
   input  logic [CDB_PORTS-1:0]        cdb_valid_in,
   input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_in,
   input  logic [CDB_PORTS*DATA_W-1:0] cdb_val_in,
   output logic                        disp_fire_out,
   output logic [DATA_W-1:0]           disp_vj_out,
   output logic [DATA_W-1:0]           disp_vk_out,
   output logic [TAG_W-1:0]            disp_qj_out,
   output logic [TAG_W-1:0]            disp_qk_out,
   output logic [DATA_W-1:0]           disp_a_out,
   output logic [TAG_W-1:0]            disp_dest_out,
   output logic [OP_W-1:0]             disp_op_out,
   output logic [ADDR_W-1:0]           disp_pc_out,
   output logic [ADDR_W-1:0]           disp_target_out,
   output logic                        disp_taken_out,
   output logic [REG_W-1:0]            disp_rd_out,
   output logic                        rf_rename_en_out,
   output logic [REG_W-1:0]            rf_rename_rd_out,
   output logic [TAG_W-1:0]            rf_rename_tag_out
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [REG_W-1:0]  rs_mem     [DEPTH];
   logic [REG_W-1:0]  rt_mem     [DEPTH];
   logic [REG_W-1:0]  rd_mem     [DEPTH];
   logic [DATA_W-1:0] imm_mem    [DEPTH];
   logic [OP_W-1:0]   op_mem     [DEPTH];
   logic [ADDR_W-1:0] pc_mem     [DEPTH];
   logic [ADDR_W-1:0] target_mem [DEPTH];
   logic              taken_mem  [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             enq, fire;
   logic [REG_W-1:0] head_rs, head_rt, head_rd;
   logic [OP_W-1:0]  head_op;

   assign dec_ready_out = !rst_in && (count_q != CNT_W'(DEPTH)) && !flush_in;
   assign enq           = dec_valid_in && dec_ready_out && rdy_in;
   assign fire          = !rst_in && rdy_in && !flush_in && (count_q != '0) &&
                          rs_ready_in && rob_ready_in;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_in) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq)  tail_d = tail_q + 1'b1;
         if (fire) head_d = head_q + 1'b1;
         count_d = count_q + CNT_W'(enq) - CNT_W'(fire);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage is never cleared; occupancy is tracked by count_q alone.
   always_ff @(posedge clk_in) begin
      if (enq) begin
         rs_mem[tail_q]     <= dec_rs_in;
         rt_mem[tail_q]     <= dec_rt_in;
         rd_mem[tail_q]     <= dec_rd_in;
         imm_mem[tail_q]    <= dec_imm_in;
         op_mem[tail_q]     <= dec_op_in;
         pc_mem[tail_q]     <= dec_pc_in;
         target_mem[tail_q] <= dec_target_in;
         taken_mem[tail_q]  <= dec_taken_in;
      end
   end

   assign head_rs = rs_mem[head_q];
   assign head_rt = rt_mem[head_q];
   assign head_rd = rd_mem[head_q];
   assign head_op = op_mem[head_q];

   assign rf_rs_out    = head_rs;
   assign rf_rt_out    = head_rt;
   assign rob_rs_h_out = rf_rs_tag_in;
   assign rob_rt_h_out = rf_rt_tag_in;

   operand_resolver #(
      .CDB_PORTS (CDB_PORTS),
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W)
   ) u_rs_res (
      .reg_zero_in  (head_rs == '0),
      .rf_busy_in   (rf_rs_busy_in),
      .rf_val_in    (rf_rs_val_in),
      .rf_tag_in    (rf_rs_tag_in),
      .rob_ready_in (rob_rs_ready_in),
      .rob_val_in   (rob_rs_val_in),
      .cdb_valid_in (cdb_valid_in),
      .cdb_tag_in   (cdb_tag_in),
      .cdb_val_in   (cdb_val_in),
      .val_out      (disp_vj_out),
      .tag_out      (disp_qj_out)
   );

   operand_resolver #(
      .CDB_PORTS (CDB_PORTS),
      .DATA_W    (DATA_W),
      .TAG_W     (TAG_W)
   ) u_rt_res (
      .reg_zero_in  (head_rt == '0),
      .rf_busy_in   (rf_rt_busy_in),
      .rf_val_in    (rf_rt_val_in),
      .rf_tag_in    (rf_rt_tag_in),
      .rob_ready_in (rob_rt_ready_in),
      .rob_val_in   (rob_rt_val_in),
      .cdb_valid_in (cdb_valid_in),
      .cdb_tag_in   (cdb_tag_in),
      .cdb_val_in   (cdb_val_in),
      .val_out      (disp_vk_out),
      .tag_out      (disp_qk_out)
   );

   assign disp_fire_out     = fire;
   assign disp_a_out        = imm_mem[head_q];
   assign disp_dest_out     = rob_free_tag_in;
   assign disp_op_out       = head_op;
   assign disp_pc_out       = pc_mem[head_q];
   assign disp_target_out   = target_mem[head_q];
   assign disp_taken_out    = taken_mem[head_q];
   assign disp_rd_out       = head_rd;
   assign rf_rename_rd_out  = head_rd;
   assign rf_rename_tag_out = rob_free_tag_in;
   assign rf_rename_en_out  = fire && !is_branch(OPC_W'(head_op)) && !is_store(OPC_W'(head_op)) &&
                              (head_rd != '0);

endmodule
